// File: rtl/tlb_access_ctrl_pkg.sv
// Shared TLB entry layout, owner/state encodings and the CS-limit check.
// Latency: n/a (declarations and a pure combinational helper).
// Backpressure: n/a.
package tlb_access_ctrl_pkg;

    localparam int N_ENTRIES      = 8;
    localparam int ENTRY_W        = 44;
    localparam int IDX_W          = 3;
    localparam int STARVE_MAX_DEF = 3;

    // Entry field positions
    localparam int VPN_HI = 43;
    localparam int VPN_LO = 24;
    localparam int VPN_W  = VPN_HI - VPN_LO + 1;
    localparam int PFN_HI = 6;
    localparam int PFN_LO = 4;
    localparam int PFN_W  = PFN_HI - PFN_LO + 1;
    localparam int V_BIT  = 3;
    localparam int P_BIT  = 2;

    // Reserved spans, only used to sink unused bits
    localparam int RSVD_HI_LO = PFN_HI + 1;
    localparam int RSVD_HI_W  = VPN_LO - PFN_HI - 1;
    localparam int RSVD_LO_W  = P_BIT;

    // Response / fault owner
    localparam logic SRC_FETCH = 1'b0;
    localparam logic SRC_MEM   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    // The offset is rounded up to the end of its 32-byte chunk before comparing.
    function automatic logic prot_violation(input logic [31:0] off, input logic [19:0] lim);
        return {off[31:5], 5'h1F} > {12'h0, lim};
    endfunction

endpackage

// File: rtl/tlb_access_ctrl_match.sv
// Fully associative VPN match over all entries with lowest-index priority.
// Latency: combinational.
// Backpressure: none.
module tlb_entry_match
    import tlb_access_ctrl_pkg::*;
(
    input  logic [N_ENTRIES*ENTRY_W-1:0] tlb,
    input  logic [31:0]                  addr,
    output logic                         hit,
    output logic [IDX_W-1:0]             idx,
    output logic [PFN_W-1:0]             pfn
);

    logic [N_ENTRIES-1:0] match_vec;
    logic [N_ENTRIES-1:0] unused_rsvd_x;
    logic                 unused_ok;

    // One comparator per entry: VPN equal and entry both valid and present
    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_cmp
        assign match_vec[g] = (tlb[g*ENTRY_W + VPN_LO +: VPN_W] == addr[31:12])
                              && tlb[g*ENTRY_W + V_BIT]
                              && tlb[g*ENTRY_W + P_BIT];
        assign unused_rsvd_x[g] = ^{tlb[g*ENTRY_W + RSVD_HI_LO +: RSVD_HI_W],
                                    tlb[g*ENTRY_W +: RSVD_LO_W]};
    end

    assign unused_ok = ^{unused_rsvd_x, addr[11:0]};

    // Priority encode and PFN select; scanning downward leaves the lowest hit
    always_comb begin
        hit = 1'b0;
        idx = '0;
        pfn = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
                pfn = tlb[i*ENTRY_W + PFN_LO +: PFN_W];
            end
        end
    end

endmodule

// File: rtl/tlb_access_ctrl.sv
// TLB storage plus one shared lookup path arbitrated between fetch and mem.
// Latency: grant is combinational; response and fault latch are registered one cycle later.
// Backpressure: no grant during a TLB write or while a fault is latched; requesters hold req until ack.
module tlb_access_ctrl
    import tlb_access_ctrl_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         f_req,
    input  logic [31:0]                  f_address,
    input  logic [31:0]                  f_address_off,
    output logic                         f_ack,
    input  logic                         m_req,
    input  logic [31:0]                  m_address,
    output logic                         m_ack,
    input  logic [19:0]                  CS_limit,
    input  logic                         tlb_wr_en,
    input  logic [IDX_W-1:0]             tlb_wr_idx,
    input  logic [ENTRY_W-1:0]           tlb_wr_data,
    output logic [N_ENTRIES*ENTRY_W-1:0] TLB,
    output logic                         resp_valid,
    output logic                         resp_src,
    output logic [PFN_W-1:0]             resp_PFN,
    output logic                         resp_page_fault,
    output logic                         resp_prot_exp,
    output logic                         fault_pending,
    output logic [31:0]                  fault_address,
    output logic                         fault_src,
    input  logic                         fault_clr
);

    localparam int              CNT_W      = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [ENTRY_W-1:0] tlb_q [N_ENTRIES];
    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   starve_q;

    logic               grant_ok;
    logic               grant;
    logic               lk_src;
    logic [31:0]        lk_addr;
    logic               lk_prot;
    logic               lk_fault;
    logic               mt_hit;
    logic [IDX_W-1:0]   mt_idx;
    logic [PFN_W-1:0]   mt_pfn;
    logic               unused_ok;

    assign unused_ok = ^{mt_idx, f_address_off[4:0]};

    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_flat
        assign TLB[g*ENTRY_W +: ENTRY_W] = tlb_q[g];
    end

    // Entry storage; a write lands at the edge so the next grant sees it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                tlb_q[i] <= '0;
            end
        end else if (tlb_wr_en) begin
            tlb_q[tlb_wr_idx] <= tlb_wr_data;
        end
    end

    // Arbitration: writes and latched faults block; a starved fetch beats mem
    always_comb begin
        f_ack    = 1'b0;
        m_ack    = 1'b0;
        grant_ok = !rst && !tlb_wr_en && (state_q != ST_FAULT);
        if (grant_ok) begin
            if (f_req && (!m_req || starve_q == STARVE_LIM)) begin
                f_ack = 1'b1;
            end else if (m_req) begin
                m_ack = 1'b1;
            end
        end
    end

    assign grant    = f_ack | m_ack;
    assign lk_src   = m_ack ? SRC_MEM : SRC_FETCH;
    assign lk_addr  = m_ack ? m_address : f_address;
    assign lk_prot  = f_ack & prot_violation(f_address_off, CS_limit);
    assign lk_fault = grant & (~mt_hit | lk_prot);

    tlb_entry_match u_match (
        .tlb  (TLB),
        .addr (lk_addr),
        .hit  (mt_hit),
        .idx  (mt_idx),
        .pfn  (mt_pfn)
    );

    // Next state: any faulting lookup parks the block until software clears it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (lk_fault)   state_d = ST_FAULT;
                else if (grant) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (lk_fault)   state_d = ST_FAULT;
            end
            ST_FAULT: begin
                if (fault_clr)  state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    assign fault_pending = (state_q == ST_FAULT);

    // Response, fault capture (first fault wins) and fetch starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid      <= 1'b0;
            resp_src        <= 1'b0;
            resp_PFN        <= '0;
            resp_page_fault <= 1'b0;
            resp_prot_exp   <= 1'b0;
            fault_address   <= '0;
            fault_src       <= 1'b0;
            starve_q        <= '0;
        end else begin
            resp_valid      <= grant;
            resp_src        <= grant ? lk_src : 1'b0;
            resp_PFN        <= grant ? mt_pfn : '0;
            resp_page_fault <= grant & ~mt_hit;
            resp_prot_exp   <= lk_prot;
            if (lk_fault && !fault_pending) begin
                fault_address <= lk_addr;
                fault_src     <= lk_src;
            end
            if (f_req && !f_ack) begin
                if (starve_q != STARVE_LIM) starve_q <= starve_q + 1'b1;
            end else begin
                starve_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tlb_access_ctrl.sv
module tb_tlb_access_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         f_req;
    logic [31:0]  f_address;
    logic [31:0]  f_address_off;
    logic         f_ack;
    logic         m_req;
    logic [31:0]  m_address;
    logic         m_ack;
    logic [19:0]  CS_limit;
    logic         tlb_wr_en;
    logic [2:0]   tlb_wr_idx;
    logic [43:0]  tlb_wr_data;
    logic [351:0] TLB;
    logic         resp_valid;
    logic         resp_src;
    logic [2:0]   resp_PFN;
    logic         resp_page_fault;
    logic         resp_prot_exp;
    logic         fault_pending;
    logic [31:0]  fault_address;
    logic         fault_src;
    logic         fault_clr;

    int checks = 0;
    int errors = 0;

    tlb_access_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .f_req           (f_req),
        .f_address       (f_address),
        .f_address_off   (f_address_off),
        .f_ack           (f_ack),
        .m_req           (m_req),
        .m_address       (m_address),
        .m_ack           (m_ack),
        .CS_limit        (CS_limit),
        .tlb_wr_en       (tlb_wr_en),
        .tlb_wr_idx      (tlb_wr_idx),
        .tlb_wr_data     (tlb_wr_data),
        .TLB             (TLB),
        .resp_valid      (resp_valid),
        .resp_src        (resp_src),
        .resp_PFN        (resp_PFN),
        .resp_page_fault (resp_page_fault),
        .resp_prot_exp   (resp_prot_exp),
        .fault_pending   (fault_pending),
        .fault_address   (fault_address),
        .fault_src       (fault_src),
        .fault_clr       (fault_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic [31:0] f_off;
        logic        m_req;
        logic [31:0] m_addr;
        logic [19:0] cs;
        logic        wr;
        logic [2:0]  wr_idx;
        logic [43:0] wr_data;
        logic        clr;
        logic        e_fack;
        logic        e_mack;
        logic        e_vld;
        logic        e_src;
        logic [2:0]  e_pfn;
        logic        e_pf;
        logic        e_prot;
        logic        e_fp;
        logic [31:0] e_faddr;
        logic        e_fsrc;
    } vec_t;

    vec_t vt[$];

    localparam logic [31:0] AF  = 32'h12345ABC;  // fetch address, hits entry 2
    localparam logic [31:0] AM  = 32'h00010F00;  // mem address, hits entries 0 and 1
    localparam logic [19:0] LMX = 20'hFFFFF;

    logic [43:0] e0, e1, e2, e4;

    function automatic logic [43:0] mk_entry(input logic [19:0] vpn, input logic [2:0] pfn,
                                             input logic v, input logic p);
        return {vpn, 17'h0, pfn, v, p, 2'b00};
    endfunction

    function automatic void add(input int fr, input logic [31:0] fad, input logic [31:0] foff,
                                input int mr, input logic [31:0] mad, input logic [19:0] cs,
                                input int wr, input int widx, input logic [43:0] wdat, input int clr,
                                input int fa, input int ma, input int vld, input int src,
                                input int pfn, input int pf, input int prot, input int fp,
                                input logic [31:0] faddr, input int fsrc);
        vec_t v;
        v.f_req = fr[0];   v.f_addr = fad;  v.f_off = foff;
        v.m_req = mr[0];   v.m_addr = mad;  v.cs = cs;
        v.wr = wr[0];      v.wr_idx = widx[2:0];  v.wr_data = wdat;  v.clr = clr[0];
        v.e_fack = fa[0];  v.e_mack = ma[0];  v.e_vld = vld[0];  v.e_src = src[0];
        v.e_pfn = pfn[2:0];  v.e_pf = pf[0];  v.e_prot = prot[0];  v.e_fp = fp[0];
        v.e_faddr = faddr;   v.e_fsrc = fsrc[0];
        vt.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        f_req = 1'b0; f_address = '0; f_address_off = '0;
        m_req = 1'b0; m_address = '0; CS_limit = LMX;
        tlb_wr_en = 1'b0; tlb_wr_idx = '0; tlb_wr_data = '0; fault_clr = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int k);
        f_req = v.f_req; f_address = v.f_addr; f_address_off = v.f_off;
        m_req = v.m_req; m_address = v.m_addr; CS_limit = v.cs;
        tlb_wr_en = v.wr; tlb_wr_idx = v.wr_idx; tlb_wr_data = v.wr_data;
        fault_clr = v.clr;
        #1;
        chk($sformatf("v%0d f_ack", k), 64'(f_ack), 64'(v.e_fack));
        chk($sformatf("v%0d m_ack", k), 64'(m_ack), 64'(v.e_mack));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d resp_valid", k), 64'(resp_valid), 64'(v.e_vld));
        if (v.e_vld) begin
            chk($sformatf("v%0d resp_src", k), 64'(resp_src), 64'(v.e_src));
            chk($sformatf("v%0d resp_PFN", k), 64'(resp_PFN), 64'(v.e_pfn));
            chk($sformatf("v%0d resp_page_fault", k), 64'(resp_page_fault), 64'(v.e_pf));
            chk($sformatf("v%0d resp_prot_exp", k), 64'(resp_prot_exp), 64'(v.e_prot));
        end
        chk($sformatf("v%0d fault_pending", k), 64'(fault_pending), 64'(v.e_fp));
        chk($sformatf("v%0d fault_address", k), 64'(fault_address), 64'(v.e_faddr));
        chk($sformatf("v%0d fault_src", k), 64'(fault_src), 64'(v.e_fsrc));
    endtask

    initial begin
        e0 = mk_entry(20'h00010, 3'd1, 1'b1, 1'b1);
        e1 = mk_entry(20'h00010, 3'd3, 1'b1, 1'b1);  // duplicate VPN, loses to entry 0
        e2 = mk_entry(20'h12345, 3'd5, 1'b1, 1'b1);
        e4 = mk_entry(20'h00020, 3'd6, 1'b1, 1'b0);  // valid but not present

        //  f_req f_addr f_off  m_req m_addr  cs  wr idx data clr | fa ma vld src pfn pf prot fp faddr fsrc
        add(1, AF, 0,      0, 0,            LMX,    1, 2, e2, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // write wins
        add(1, AF, 0,      0, 0,            LMX,    0, 0, '0, 0,   1, 0, 1, 0, 5, 0, 0, 0, 0, 0);  // sees new entry
        add(0, 0,  0,      0, 0,            LMX,    1, 0, e0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0,  0,      0, 0,            LMX,    1, 1, e1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0,  0,      0, 0,            LMX,    1, 4, e4, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, AF, 0,      1, AM,           LMX,    0, 0, '0, 0,   0, 1, 1, 1, 1, 0, 0, 0, 0, 0);  // starve 1
        add(1, AF, 0,      1, AM,           LMX,    0, 0, '0, 0,   0, 1, 1, 1, 1, 0, 0, 0, 0, 0);  // starve 2
        add(1, AF, 0,      1, AM,           LMX,    0, 0, '0, 0,   0, 1, 1, 1, 1, 0, 0, 0, 0, 0);  // starve 3
        add(1, AF, 0,      1, AM,           LMX,    0, 0, '0, 0,   1, 0, 1, 0, 5, 0, 0, 0, 0, 0);  // forced fetch
        add(1, AF, 0,      1, AM,           LMX,    0, 0, '0, 0,   0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        add(1, AF, 0,      1, AM,           LMX,    0, 0, '0, 0,   0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0,  0,      0, 0,            LMX,    0, 0, '0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // clr in RUN
        add(1, AF, 32'hE0, 0, 0,            20'h100, 0, 0, '0, 0,  1, 0, 1, 0, 5, 0, 0, 0, 0, 0);  // 0xFF ok
        add(0, AF, 32'h120, 1, 32'h00010000, 20'h100, 0, 0, '0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);  // mem no prot
        add(1, AF, 32'h120, 0, 0,           20'h100, 0, 0, '0, 0,  1, 0, 1, 0, 5, 0, 1, 1, AF, 0); // 0x13F > 0x100
        add(1, AF, 0,      1, AM,           LMX,    0, 0, '0, 0,   0, 0, 0, 0, 0, 0, 0, 1, AF, 0);
        add(1, AF, 0,      1, AM,           LMX,    0, 0, '0, 1,   0, 0, 0, 0, 0, 0, 0, 0, AF, 0);
        add(0, 0,  0,      1, 32'h00020000, LMX,    0, 0, '0, 0,   0, 1, 1, 1, 0, 1, 0, 1, 32'h00020000, 1);
        add(0, 0,  0,      1, 32'hDEAD0000, LMX,    0, 0, '0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 32'h00020000, 1);
        add(0, 0,  0,      1, 32'hDEAD0000, LMX,    0, 0, '0, 0,   0, 1, 1, 1, 0, 1, 0, 1, 32'hDEAD0000, 1);
        add(0, 0,  0,      0, 0,            LMX,    0, 0, '0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD0000, 1);
        add(0, 0,  0,      1, AM,           LMX,    0, 0, '0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD0000, 1);
        add(0, 0,  0,      1, AM,           LMX,    0, 0, '0, 0,   0, 1, 1, 1, 1, 0, 0, 0, 32'hDEAD0000, 1);

        // Reset: requests present must not be acked, everything clears
        drive_idle();
        rst = 1'b1;
        f_req = 1'b1;
        f_address = AF;
        m_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst f_ack", 64'(f_ack), 64'd0);
        chk("rst m_ack", 64'(m_ack), 64'd0);
        chk("rst resp_valid", 64'(resp_valid), 64'd0);
        chk("rst fault_pending", 64'(fault_pending), 64'd0);
        chk("rst fault_address", 64'(fault_address), 64'd0);
        chk("rst tlb_any", 64'(|TLB), 64'd0);
        rst = 1'b0;
        drive_idle();

        foreach (vt[k]) begin
            @(negedge clk);
            apply(vt[k], k);
        end

        @(negedge clk);
        drive_idle();
        chk("tlb e1", 64'(TLB[1*44 +: 44]), 64'(e1));
        chk("tlb e2", 64'(TLB[2*44 +: 44]), 64'(e2));

        // Reset in the cycle after a grant drops the response and clears storage
        m_req = 1'b1;
        m_address = AM;
        #1;
        chk("mid m_ack", 64'(m_ack), 64'd1);
        @(posedge clk);
        #1;
        chk("mid resp_valid pre", 64'(resp_valid), 64'd1);
        @(negedge clk);
        m_req = 1'b0;
        rst = 1'b1;
        f_req = 1'b1;
        f_address = AF;
        #1;
        chk("mid rst f_ack", 64'(f_ack), 64'd0);
        @(posedge clk);
        #1;
        chk("mid resp_valid", 64'(resp_valid), 64'd0);
        chk("mid tlb_any", 64'(|TLB), 64'd0);
        chk("mid fault_address", 64'(fault_address), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post f_ack", 64'(f_ack), 64'd1);
        @(posedge clk);
        #1;
        chk("post resp_valid", 64'(resp_valid), 64'd1);
        chk("post page_fault", 64'(resp_page_fault), 64'd1);
        chk("post resp_PFN", 64'(resp_PFN), 64'd0);
        chk("post fault_pending", 64'(fault_pending), 64'd1);
        chk("post fault_address", 64'(fault_address), 64'(AF));
        chk("post fault_src", 64'(fault_src), 64'd0);
        @(negedge clk);
        drive_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
